// File: rtl/aes_key_expander.sv
// aes_key_expander: run-time selectable AES-128/192/256 key schedule engine.
// Expands the cipher key one 32-bit word per cycle into a round-key store and
// then serves any round key by index with a 1-cycle registered read.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              request expansion (sampled only while idle)
//   key_len_i            00=128, 01=192, 10=256, 11=illegal
//   key_in_i  [0:255]    cipher key, bit 0 = MSB of byte 0
//   busy_o               expansion in progress
//   done_o               one-cycle pulse on completion
//   err_o                one-cycle pulse on a rejected start
//   keys_ok_o            store holds a complete schedule
//   num_rounds_o         Nr of the stored schedule, 0 when keys_ok_o=0
//   rk_rd_i, rk_addr_i   round-key read strobe and index
//   rk_valid_o, rk_out_o read response one cycle later, word 0 at [0:31]
module aes_key_expander #(
  parameter int unsigned MAX_NK = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   key_len_i,
  input  logic [0:255] key_in_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         keys_ok_o,
  output logic [3:0]   num_rounds_o,
  input  logic         rk_rd_i,
  input  logic [3:0]   rk_addr_i,
  output logic         rk_valid_o,
  output logic [0:127] rk_out_o
);

  localparam int unsigned NumRk    = MAX_NK + 7;
  localparam int unsigned NumWords = 4 * NumRk;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StExpand = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, with 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      2'b00:   return 4'd10;
      2'b01:   return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(input logic [1:0] kl);
    case (kl)
      2'b00:   return 6'd44;
      2'b01:   return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  logic [1:0]   state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   mod_q, mod_d;       // i mod Nk, tracked incrementally
  logic [7:0]   rcon_q, rcon_d;
  logic [1:0]   klen_q, klen_d;
  logic         keys_ok_q, keys_ok_d;
  logic [3:0]   nr_q, nr_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         rk_valid_q;
  logic [0:127] rk_out_q;

  // Window holds the last Nk words, newest at index MAX_NK-1.
  logic [31:0]  win_q [MAX_NK];
  logic [31:0]  win_d [MAX_NK];
  logic [31:0]  store_q [NumWords];

  logic [31:0]  key_w [8];
  logic [3:0]   nk_cur;
  logic [5:0]   nw_cur;
  int           win_base;
  logic         idle;
  logic         len_legal;
  logic         start_ok;
  logic         start_bad;
  logic [31:0]  w_prev;
  logic [31:0]  w_old;
  logic [31:0]  rot_w;
  logic [31:0]  sw_in;
  logic [31:0]  sw_out;
  logic [31:0]  temp;
  logic [31:0]  new_word;
  logic         rd_ok;
  logic [127:0] rd_data;

  assign nk_cur    = nk_of(klen_q);
  assign nw_cur    = nw_of(klen_q);
  assign win_base  = int'(MAX_NK) - int'(nk_cur);
  assign idle      = (state_q == StIdle);
  assign len_legal = (key_len_i != 2'b11) && (32'(nk_of(key_len_i)) <= MAX_NK);
  assign start_ok  = start_i && idle && len_legal;
  assign start_bad = start_i && idle && !len_legal;

  always_comb begin
    for (int k = 0; k < 8; k++) key_w[k] = key_in_i[32*k +: 32];
  end

  // w[i-Nk] sits Nk slots back from the newest entry of the window.
  always_comb begin
    w_old = '0;
    for (int j = 0; j < int'(MAX_NK); j++) begin
      if (j == win_base) w_old = win_q[j];
    end
  end

  assign w_prev = win_q[MAX_NK-1];
  assign rot_w  = {w_prev[23:0], w_prev[31:24]};
  assign sw_in  = (mod_q == 3'd0) ? rot_w : w_prev;
  assign sw_out = {sbox(sw_in[31:24]), sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0])};

  always_comb begin
    temp = w_prev;
    if (mod_q == 3'd0) begin
      temp = sw_out ^ {rcon_q, 24'h0};
    end else if ((nk_cur == 4'd8) && (mod_q == 3'd4)) begin
      temp = sw_out;
    end
  end

  assign new_word = w_old ^ temp;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    mod_d     = mod_q;
    rcon_d    = rcon_q;
    klen_d    = klen_q;
    keys_ok_d = keys_ok_q;
    nr_d      = nr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    win_d     = win_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d   = StLoad;
          keys_ok_d = 1'b0;
          klen_d    = key_len_i;
          i_d       = {2'b00, nk_of(key_len_i)};
          mod_d     = 3'd0;
          rcon_d    = 8'h01;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end
      StLoad: begin
        state_d = StExpand;
        for (int j = 0; j < int'(MAX_NK); j++) begin
          if (j >= win_base) win_d[j] = key_w[3'(j - win_base)];
        end
      end
      StExpand: begin
        for (int j = 0; j < int'(MAX_NK) - 1; j++) win_d[j] = win_q[j+1];
        win_d[MAX_NK-1] = new_word;
        i_d   = i_q + 6'd1;
        mod_d = ({1'b0, mod_q} == nk_cur - 4'd1) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == nw_cur - 6'd1) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          keys_ok_d = 1'b1;
          nr_d      = nr_of(klen_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      i_q       <= '0;
      mod_q     <= '0;
      rcon_q    <= 8'h01;
      klen_q    <= 2'b00;
      keys_ok_q <= 1'b0;
      nr_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      mod_q     <= mod_d;
      rcon_q    <= rcon_d;
      klen_q    <= klen_d;
      keys_ok_q <= keys_ok_d;
      nr_q      <= nr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Window and store carry no reset; their contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    win_q <= win_d;
    if (state_q == StLoad) begin
      for (int k = 0; k < int'(MAX_NK); k++) begin
        if (4'(k) < nk_cur) store_q[k] <= key_w[k];
      end
    end else if (state_q == StExpand) begin
      for (int w = 0; w < int'(NumWords); w++) begin
        if (i_q == 6'(w)) store_q[w] <= new_word;
      end
    end
  end

  assign rd_ok = rk_rd_i && keys_ok_q && (rk_addr_i <= nr_q);

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < int'(NumRk); r++) begin
      if (rk_addr_i == 4'(r)) begin
        rd_data = {store_q[4*r], store_q[4*r+1], store_q[4*r+2], store_q[4*r+3]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
    end else begin
      rk_valid_q <= rd_ok;
      rk_out_q   <= rd_ok ? rd_data : '0;
    end
  end

  assign busy_o       = !idle;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign keys_ok_o    = keys_ok_q;
  assign num_rounds_o = keys_ok_q ? nr_q : 4'd0;
  assign rk_valid_o   = rk_valid_q;
  assign rk_out_o     = rk_out_q;

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [0:255] key_in;
  logic         rk_rd;
  logic [3:0]   rk_addr;

  logic         busy, done, err, keys_ok, rk_valid;
  logic [3:0]   num_rounds;
  logic [0:127] rk_out;

  logic         busy4, done4, err4, keys_ok4, rk_valid4;
  logic [3:0]   num_rounds4;
  logic [0:127] rk_out4;

  int checks = 0;
  int failures = 0;

  logic [127:0] rk128 [0:10];
  logic [0:255] k128, k192, k256;

  aes_key_expander #(.MAX_NK(8)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .key_len_i    (key_len),
    .key_in_i     (key_in),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .keys_ok_o    (keys_ok),
    .num_rounds_o (num_rounds),
    .rk_rd_i      (rk_rd),
    .rk_addr_i    (rk_addr),
    .rk_valid_o   (rk_valid),
    .rk_out_o     (rk_out)
  );

  aes_key_expander #(.MAX_NK(4)) u_dut4 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .key_len_i    (key_len),
    .key_in_i     (key_in),
    .busy_o       (busy4),
    .done_o       (done4),
    .err_o        (err4),
    .keys_ok_o    (keys_ok4),
    .num_rounds_o (num_rounds4),
    .rk_rd_i      (rk_rd),
    .rk_addr_i    (rk_addr),
    .rk_valid_o   (rk_valid4),
    .rk_out_o     (rk_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic ev, input logic [127:0] ed);
    rk_rd   = 1'b1;
    rk_addr = a;
    @(posedge clk); #1;
    rk_rd = 1'b0;
    chk($sformatf("rk%0d valid", a), 128'(rk_valid), 128'(ev));
    chk($sformatf("rk%0d data", a), rk_out, ed);
  endtask

  task automatic run(input logic [1:0] kl, input logic [0:255] k, input int lat,
                     input logic exp_err4);
    int   n;
    logic seen;
    n       = 0;
    seen    = 1'b0;
    key_len = kl;
    key_in  = k;
    start   = 1'b1;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n == 1) begin
        chk("busy after start", 128'(busy), 128'(1));
        chk("narrow err after start", 128'(err4), 128'(exp_err4));
      end
      if (done) seen = 1'b1;
    end
    chk($sformatf("done latency kl=%0d", kl), 128'(n), 128'(lat));
    chk("keys_ok at done", 128'(keys_ok), 128'(1));
    chk("busy at done", 128'(busy), 128'(0));
  endtask

  initial begin
    rk128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    rst_n   = 1'b0;
    start   = 1'b0;
    key_len = 2'b00;
    key_in  = '0;
    rk_rd   = 1'b0;
    rk_addr = 4'd0;
    #1;
    chk("reset flags", 128'({busy, done, err, keys_ok, num_rounds, rk_valid}), 128'(0));
    chk("reset rk_out", rk_out, 128'(0));
    #21;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AES-128
    run(2'b00, k128, 42, 1'b0);
    chk("nr 128", 128'(num_rounds), 128'(10));
    chk("narrow keys_ok 128", 128'(keys_ok4), 128'(1));
    for (int a = 14; a >= 0; a--) begin
      if (a > 10) rd(4'(a), 1'b0, 128'(0));
      else        rd(4'(a), 1'b1, rk128[a]);
    end

    // Illegal key length: one err pulse, schedule untouched
    key_len = 2'b11;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err on illegal len", 128'(err), 128'(1));
    chk("busy on illegal len", 128'(busy), 128'(0));
    chk("keys_ok kept", 128'(keys_ok), 128'(1));
    chk("nr kept", 128'(num_rounds), 128'(10));
    @(posedge clk); #1;
    chk("err single pulse", 128'(err), 128'(0));
    rd(4'd10, 1'b1, rk128[10]);

    // AES-192; the MAX_NK=4 instance rejects it
    run(2'b01, k192, 48, 1'b1);
    chk("nr 192", 128'(num_rounds), 128'(12));
    rd(4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
    rd(4'd13, 1'b0, 128'(0));
    rd(4'd0, 1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5);

    // AES-256; MAX_NK=4 instance rejects and keeps its AES-128 schedule
    run(2'b10, k256, 54, 1'b1);
    rd(4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
    chk("nr 256", 128'(num_rounds), 128'(14));
    rd(4'd1, 1'b1, 128'h1f352c073b6108d72d9810a30914dff4);
    chk("narrow keys_ok kept", 128'(keys_ok4), 128'(1));
    chk("narrow nr kept", 128'(num_rounds4), 128'(10));
    rk_rd   = 1'b1;
    rk_addr = 4'd10;
    @(posedge clk); #1;
    rk_rd = 1'b0;
    chk("narrow rk10 valid", 128'(rk_valid4), 128'(1));
    chk("narrow rk10 data", rk_out4, rk128[10]);

    // Reset in the middle of an expansion, then restart
    key_len = 2'b00;
    key_in  = k128;
    start   = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 10) begin
        rk_rd   = 1'b1;
        rk_addr = 4'd0;
      end
      if (n == 11) begin
        rk_rd = 1'b0;
        chk("read while busy", 128'({rk_valid, rk_out}), 128'(0));
      end
    end
    chk("busy mid expansion", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("async reset flags", 128'({busy, done, err, keys_ok, num_rounds, rk_valid}), 128'(0));
    chk("async reset rk_out", rk_out, 128'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("keys_ok after reset", 128'(keys_ok), 128'(0));
    run(2'b00, k128, 42, 1'b0);
    rd(4'd10, 1'b1, rk128[10]);
    rd(4'd5, 1'b1, rk128[5]);
    chk("nr after restart", 128'(num_rounds), 128'(10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential, parametrised AES key-schedule engine supporting AES-128/192/256, selected at run time. It expands a cipher key one 32-bit word per cycle into an internal round-key store, then serves any round key by index with 1-cycle read latency. It feeds both the encrypt datapath (ascending index) and the decrypt datapath (descending index) from a single expansion. It replaces per-round combinational key generation chained through the cipher core.

## Interface

Parameters:
- MAX_NK, 8, largest supported key length in words (4, 6 or 8). Sizes the sliding window to MAX_NK words and the store to MAX_NK+7 round keys. A key_len above this limit is rejected.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request expansion; sampled only when busy=0
- key_len  in  2  00=128, 01=192, 10=256, 11=illegal
- key_in  in  [0:255]  cipher key, bit 0 = MSB of byte 0. AES-128 uses [0:127], AES-192 uses [0:191].
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when expansion completes
- err  out  1  one-cycle pulse when a start is rejected
- keys_ok  out  1  store holds a complete schedule
- num_rounds  out  4  Nr of the stored schedule (10/12/14); 0 when keys_ok=0
- rk_rd  in  1  round-key read strobe
- rk_addr  in  4  round index 0..Nr
- rk_valid  out  1  rk_out valid this cycle
- rk_out  out  [0:127]  round key; word 0 at [0:31]

## Operation

- Nk = 4/6/8 and Nr = 10/12/14. Total words Nw = 4(Nr+1) = 44/52/60.
- States:
  - IDLE to LOAD on an accepted start.
  - LOAD to EXPAND after 1 cycle.
  - EXPAND to IDLE after the word with index Nw-1 is written.
- Accepted start: busy=0 and key_len is legal and Nk <= MAX_NK. On acceptance:
  - keys_ok clears.
  - key_len is latched.
  - i is set to Nk.
  - rcon is set to 0x01.
- Rejected start (illegal key_len or Nk > MAX_NK): err pulses the next cycle. State, store, keys_ok and num_rounds are unchanged.
- start while busy=1: ignored, no err.
- LOAD: words 0..Nk-1 of key_in are written to the store and to the window.
- EXPAND computes one word w[i] per cycle, with temp = w[i-1]:
  - if i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon <= xtime(rcon). xtime is a left shift by 1, XORed with 0x1b if the MSB was set.
  - else if Nk = 8 and i mod Nk = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp. The word is written to the store and shifted into the window, and i increments.
- SubWord uses four instances of the existing sbox (high-nibble, low-nibble inputs).
- Reads:
  - rk_rd with keys_ok=1 and rk_addr <= num_rounds: the next cycle gives rk_valid=1 and rk_out = words 4*rk_addr .. 4*rk_addr+3.
  - Otherwise, including any read while busy=1 or with rk_addr > num_rounds: rk_valid=0 and rk_out = 0.
  - Reads never stall expansion.

## Timing

- Reset values: busy=0, done=0, err=0, keys_ok=0, num_rounds=0, rk_valid=0, rk_out=0. State is IDLE, and the store contents are don't-care.
- start accepted at cycle T:
  - LOAD runs at T+1, and busy is high from T+1.
  - EXPAND runs from T+2 to T+1+(Nw-Nk).
  - done=1, keys_ok=1 and busy=0 all take effect at T+2+(Nw-Nk): T+42 for AES-128, T+48 for AES-192, T+54 for AES-256.
- A new start is accepted in the cycle done is high.
- Read latency is exactly 1 cycle. rk_rd in the same cycle as done returns valid data.
- rst_n low at any point: all outputs return to reset values immediately (asynchronously). keys_ok is 0 after reset until a complete expansion finishes.

## Test plan

- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - done at T+42.
  - rk 1 = a0fafe1788542cb123a339392a6c7605.
  - rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - num_rounds = 10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done at T+48.
  - rk 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done at T+54.
  - rk 14 = fe4890d1e6188d0b046df344706c631e.
  - This exercises the i mod 8 = 4 SubWord path.
- key_len=11, and separately key_len=10 with MAX_NK=4:
  - err pulses once.
  - keys_ok and the previous schedule are preserved.
- Reads rk 14 down to rk 0 after the AES-128 run:
  - rk_addr 14..11 give rk_valid=0 and rk_out=0.
  - rk_addr 10..0 match the FIPS-197 vectors, 1-cycle latency each.
- Negative-edge rst_n at mid-expansion (T+20), then release and restart with AES-128:
  - all outputs are at reset values immediately.
  - the restart gives a correct schedule and done at the correct cycle.
